// File: rtl/xlr8_dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, port indices
// and default starvation / burst limits.
package xlr8_dm_arb_pkg;

    // Which requester owned a read in the previous cycle.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CORE    = 2'd1,
        S_XB      = 2'd2,
        S_XB_LOCK = 2'd3
    } owner_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_XB   = 1'b1;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned BURST_MAX_DEF  = 8;

endpackage

// File: rtl/xlr8_dm_arb_starve.sv
// Saturating up-counter with synchronous clear; sat flags the limit.
// Used for X starvation and, in burst builds, for the locked-burst length.
module xlr8_dm_arb_starve #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority; otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MaxVal);

endmodule

// File: rtl/xlr8_dm_arb.sv
// Data-memory arbiter between the AVR core (C) and an XB/DMA master (X) for a
// single-port RAM with registered address. Core has fixed priority; X is forced
// through after STARVE_MAX denied cycles. Read data returns one cycle after the
// grant with a valid strobe for the previous owner.
// Optional locked bursts for X: define XLR8_DM_ARB_BURST_EN.
module xlr8_dm_arb
    import xlr8_dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned BURST_MAX  = BURST_MAX_DEF
) (
    input  logic              cp2,
    input  logic              ireset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [7:0]        core_wdata,
    output logic              core_wait,
    output logic [7:0]        core_rdata,
    output logic              core_rvalid,
    input  logic              xb_req,
    input  logic              xb_we,
    input  logic [ADDR_W-1:0] xb_addr,
    input  logic [7:0]        xb_wdata,
    input  logic              xb_lock,
    output logic              xb_gnt,
    output logic [7:0]        xb_rdata,
    output logic              xb_rvalid,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    owner_e state_q, state_d;
    logic   starve_sat;
    logic   starve_inc;
    logic   lock_hold;
    logic   force_x;
    logic   gnt_x;
    logic   gnt_c;
    logic   sel;

    assign force_x   = xb_req & (starve_sat | lock_hold);
    assign gnt_x     = force_x | (xb_req & ~core_req);
    assign gnt_c     = core_req & ~gnt_x;
    assign core_wait = core_req & ~gnt_c;
    assign xb_gnt    = gnt_x;

    assign starve_inc = xb_req & ~gnt_x;

    xlr8_dm_arb_starve #(
        .W   (4),
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (cp2),
        .rst_n (ireset),
        .inc   (starve_inc),
        .clr   (~starve_inc),
        .sat   (starve_sat)
    );

`ifdef XLR8_DM_ARB_BURST_EN
    logic burst_sat;
    logic burst_inc;
    logic xb_rd_q;

    // Every granted locked X cycle counts toward the burst, including the entry.
    assign burst_inc = gnt_x & xb_lock;
    assign lock_hold = (state_q == S_XB_LOCK) & xb_lock & ~burst_sat;

    xlr8_dm_arb_starve #(
        .W   (8),
        .MAX (BURST_MAX)
    ) u_burst (
        .clk   (cp2),
        .rst_n (ireset),
        .inc   (burst_inc),
        .clr   (~burst_inc | burst_sat),
        .sat   (burst_sat)
    );

    // Remembers whether last cycle's X grant was a read (locked cycles may be writes).
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            xb_rd_q <= 1'b0;
        end else begin
            xb_rd_q <= gnt_x & ~xb_we;
        end
    end

    assign xb_rvalid = (state_q == S_XB) | ((state_q == S_XB_LOCK) & xb_rd_q);
`else
    logic unused_lock;
    localparam int unsigned unused_burst_max = BURST_MAX;

    assign unused_lock = xb_lock;
    assign lock_hold   = 1'b0;
    assign xb_rvalid   = (state_q == S_XB);
`endif

    // RAM port mux: core fields by default, X fields only while X is granted.
    assign sel    = gnt_x ? PORT_XB : PORT_CORE;
    assign ram_ce = gnt_c | gnt_x;

    always_comb begin
        ram_addr = core_addr;
        ram_din  = core_wdata;
        ram_we   = gnt_c & core_we;
        if (sel == PORT_XB) begin
            ram_addr = xb_addr;
            ram_din  = xb_wdata;
            ram_we   = xb_we;
        end
    end

    // Owner next state: which port's read (if any) was granted this cycle.
    always_comb begin
        state_d = S_IDLE;
        if (gnt_c && !core_we) begin
            state_d = S_CORE;
        end else if (gnt_x && !xb_we) begin
            state_d = S_XB;
        end
`ifdef XLR8_DM_ARB_BURST_EN
        if (gnt_x && xb_lock && !burst_sat) begin
            state_d = S_XB_LOCK;
        end
`endif
    end

    // Owner register; reset drops any read still in flight.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign core_rvalid = (state_q == S_CORE);
    assign core_rdata  = ram_dout;
    assign xb_rdata    = ram_dout;

endmodule

// File: tb/tb_xlr8_dm_arb.sv
// Scoreboard bench for xlr8_dm_arb: directed stimulus pushes expected per-cycle
// grant/RAM values and expected read returns; a negedge monitor pops and checks.
module tb_xlr8_dm_arb;

    localparam int P_NONE = 0;
    localparam int P_C    = 1;
    localparam int P_X    = 2;

    logic        cp2 = 1'b0;
    logic        ireset;
    logic        core_req, core_we, core_wait, core_rvalid;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata, core_rdata;
    logic        xb_req, xb_we, xb_lock, xb_gnt, xb_rvalid;
    logic [15:0] xb_addr;
    logic [7:0]  xb_wdata, xb_rdata;
    logic        ram_ce, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;

    always #5 cp2 = ~cp2;

    xlr8_dm_arb #(
        .ADDR_W     (16),
        .STARVE_MAX (4),
        .BURST_MAX  (8)
    ) dut (
        .cp2         (cp2),
        .ireset      (ireset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_wait   (core_wait),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .xb_req      (xb_req),
        .xb_we       (xb_we),
        .xb_addr     (xb_addr),
        .xb_wdata    (xb_wdata),
        .xb_lock     (xb_lock),
        .xb_gnt      (xb_gnt),
        .xb_rdata    (xb_rdata),
        .xb_rvalid   (xb_rvalid),
        .ram_ce      (ram_ce),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Single-port RAM model: registered address, unregistered read data.
    logic [7:0]  mem [0:65535];
    logic [15:0] addr_q;
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;

    always @(posedge cp2) begin
        if (pre_en) begin
            mem[pre_addr] = pre_data;
        end else if (ram_ce) begin
            if (ram_we) mem[ram_addr] = ram_din;
            addr_q <= ram_addr;
        end
    end
    assign ram_dout = mem[addr_q];

    int cyc = 0;
    always @(posedge cp2) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cwait;
        logic        xgnt;
        logic        ce;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  din;
    } cyc_exp_t;

    typedef struct {
        int         cyc;
        int         port;
        logic [7:0] data;
    } rd_exp_t;

    cyc_exp_t cyc_q[$];
    rd_exp_t  rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle grant/RAM expectations and read-return scoreboard.
    always @(negedge cp2) begin
        cyc_exp_t e;
        rd_exp_t  r;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("core_wait", 32'(core_wait), 32'(e.cwait));
            chk("xb_gnt", 32'(xb_gnt), 32'(e.xgnt));
            chk("ram_ce", 32'(ram_ce), 32'(e.ce));
            chk("ram_we", 32'(ram_we), 32'(e.we));
            chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            if (e.we) chk("ram_din", 32'(ram_din), 32'(e.din));
        end
        chk("rvalid_exclusive", 32'(core_rvalid & xb_rvalid), 0);
        if (core_rvalid || xb_rvalid) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rvalid", 32'({core_rvalid, xb_rvalid}), 0);
            end else begin
                r = rd_q.pop_front();
                chk("rvalid_cycle", cyc, r.cyc);
                chk("core_rvalid", 32'(core_rvalid), 32'(r.port == P_C));
                chk("xb_rvalid", 32'(xb_rvalid), 32'(r.port == P_X));
                chk("rdata", 32'(r.port == P_C ? core_rdata : xb_rdata), 32'(r.data));
            end
        end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            r = rd_q.pop_front();
            chk("missing_rvalid", 32'({core_rvalid, xb_rvalid}),
                32'(r.port == P_C ? 2'b10 : 2'b01));
        end
    end

    task automatic step(input logic cr, input logic cw, input logic [15:0] ca,
                        input logic [7:0] cd, input logic xr, input logic xw,
                        input logic [15:0] xa, input logic [7:0] xd, input logic xl,
                        input logic e_cwait, input logic e_xgnt, input logic e_ce,
                        input logic e_we, input logic [15:0] e_addr, input logic [7:0] e_din,
                        input int e_port, input logic [7:0] e_rd);
        @(posedge cp2);
        #1;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        xb_req = xr; xb_we = xw; xb_addr = xa; xb_wdata = xd; xb_lock = xl;
        cyc_q.push_back('{cwait: e_cwait, xgnt: e_xgnt, ce: e_ce, we: e_we,
                          addr: e_addr, din: e_din});
        if (e_port != P_NONE) rd_q.push_back('{cyc: cyc + 1, port: e_port, data: e_rd});
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 0, 0, 16'h0, 8'h0, P_NONE, 8'h0);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(posedge cp2);
        #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
    endtask

    initial begin
        bit xg;
        ireset = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        xb_req = 0; xb_we = 0; xb_addr = '0; xb_wdata = '0; xb_lock = 0;

        preload(16'h0123, 8'h3C);
        preload(16'h0010, 8'hAA);
        preload(16'h0020, 8'h55);
        @(posedge cp2);
        #1;
        pre_en = 1'b0;

        // Reset state.
        @(negedge cp2);
        chk("rst_core_rvalid", 32'(core_rvalid), 0);
        chk("rst_xb_rvalid", 32'(xb_rvalid), 0);
        chk("rst_ram_ce", 32'(ram_ce), 0);
        chk("rst_xb_gnt", 32'(xb_gnt), 0);
        // Grant logic follows requests during reset, but no read return follows.
        step(1, 0, 16'h0123, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 1, 0, 16'h0123, 8'h0, P_NONE, 8'h0);
        @(posedge cp2);
        #1;
        ireset = 1'b1; core_req = 0; core_addr = '0;

        // 1: core read, one-cycle latency.
        step(1, 0, 16'h0123, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 1, 0, 16'h0123, 8'h0, P_C, 8'h3C);
        idle();

        // 2: contention; X denied four cycles, forced on the fifth.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 0,
                 0, 0, 1, 0, 16'h0010, 8'h0, P_C, 8'hAA);
        end
        step(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 0,
             1, 1, 1, 0, 16'h0020, 8'h0, P_X, 8'h55);
        step(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 1, 0, 16'h0010, 8'h0, P_C, 8'hAA);
        idle();

        // 3: alternating owners every cycle.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0, 0,
                 0, 0, 1, 0, 16'h0010, 8'h0, P_C, 8'hAA);
            step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 0,
                 0, 1, 1, 0, 16'h0020, 8'h0, P_X, 8'h55);
        end
        idle();

        // 4: X write then core read-back.
        step(0, 0, 16'h0, 8'h0, 1, 1, 16'h0200, 8'h5A, 0,
             0, 1, 1, 1, 16'h0200, 8'h5A, P_NONE, 8'h0);
        step(1, 0, 16'h0200, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 1, 0, 16'h0200, 8'h0, P_C, 8'h5A);
        idle();

        // 5: reset right after a granted X read drops the pending rvalid.
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 0,
             0, 1, 1, 0, 16'h0020, 8'h0, P_NONE, 8'h0);
        @(posedge cp2);
        #1;
        ireset = 1'b0; xb_req = 0; xb_addr = '0;
        @(negedge cp2);
        chk("rst_drop_xb_rvalid", 32'(xb_rvalid), 0);
        @(posedge cp2);
        #1;
        ireset = 1'b1;
        idle();
        idle();
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 0,
             0, 1, 1, 0, 16'h0020, 8'h0, P_X, 8'h55);
        idle();

        // 6: X holds requests with xb_lock while the core keeps requesting.
        for (int i = 1; i <= 13; i++) begin
`ifdef XLR8_DM_ARB_BURST_EN
            xg = (i >= 5) && (i <= 12);
`else
            xg = (i == 5) || (i == 10);
`endif
            if (xg) begin
                step(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 1,
                     1, 1, 1, 0, 16'h0020, 8'h0, P_X, 8'h55);
            end else begin
                step(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 1,
                     0, 0, 1, 0, 16'h0010, 8'h0, P_C, 8'hAA);
            end
        end
        idle();
        idle();
        @(posedge cp2);
        #1;
        chk("rd_q_drained", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
